dwave_gen: RTL
==============

// Module: dwave_gen
// PURPOSE
//  Programmable pulse-train generator with optional glitch injection.
//  It is the source end of the dwave sampling path: it drives the serial
//  data line (d_out) that a dwave deglitch/sampler consumes.
//  It lets the bench and board loopback produce repeatable clean pulses,
//  plus short spurious pulses, counted in clk cycles.
// PARAMETERS
//  CNT_W    8  width of every length/count field and of the internal counters
//  GLITCH_W 1  default glitch width used when glitch_w input is 0
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst_n       in   1      async active-low reset
//  start       in   1      begin a burst (sampled only in IDLE)
//  stop        in   1      request end of burst at current period boundary
//  low_len     in   CNT_W  cycles d_out low at start of each period
//  high_len    in   CNT_W  cycles of main high pulse
//  glitch_en   in   1      append glitch phase to each period
//  glitch_gap  in   CNT_W  low cycles between main pulse and glitch
//  glitch_w    in   CNT_W  glitch high cycles (0 -> GLITCH_W)
//  n_periods   in   CNT_W  periods per burst; 0 = continuous until stop
//  d_out       out  1      generated waveform, registered
//  busy        out  1      high in every state except IDLE
//  period_done out  1      1-cycle pulse on last cycle of each period
// BEHAVIOUR
//  - Reset is one clock domain with an async active-low reset. While rst_n=0:
//    state=IDLE, d_out=0, busy=0, period_done=0, counters=0, stop_pend=0.
//    If rst_n asserts mid-burst, the burst aborts immediately and no
//    period_done is emitted.
//  - The data inputs (low_len, high_len, glitch_*, n_periods) are latched
//    on the start edge and held for the whole burst. Changing an input
//    mid-burst has no effect.
//  - A latched length of 0 is treated as 1, except n_periods, where 0
//    means continuous.
//  - FSM states: IDLE, LOW, HIGH, GAP, GLIT.
//  - IDLE: d_out=0. A start sampled high moves to LOW on the next edge.
//    busy=1 from that edge.
//  - LOW: d_out=0 for exactly low_len cycles, then HIGH.
//  - HIGH: d_out=1 for exactly high_len cycles. Next state is GAP if
//    glitch_en, otherwise end-of-period.
//  - GAP: d_out=0 for glitch_gap cycles, then GLIT.
//  - GLIT: d_out=1 for glitch_w cycles, then end-of-period.
//  - End-of-period:
//    - period_done=1 during the final cycle of HIGH (no glitch) or of
//      GLIT (glitch).
//    - The period counter increments.
//    - If stop_pend is set, or (n_periods!=0 and count==n_periods), the
//      next state is IDLE. Otherwise it is LOW.
//  - d_out is a registered function of the state; there is no
//    combinational path from any input to d_out.
//  - First-edge latency: start high at edge k gives d_out low at edge
//    k+1 (LOW entered). The first rise occurs at edge k+1+low_len.
//  - stop: sets stop_pend in any non-IDLE state. The current period always
//    completes, so d_out never truncates a pulse. stop in IDLE is ignored.
//    stop_pend clears on entry to IDLE.
//  - Simultaneous start and stop in IDLE: start wins. The burst runs
//    exactly one period, then returns to IDLE.
//  - start while busy is ignored.
//  - Period counter: CNT_W bits. In continuous mode it wraps 2^CNT_W-1 -> 0
//    with no effect on the output.
//  - Period length = low_len + high_len [+ glitch_gap + glitch_w] cycles.
//    Bursts are back-to-back with no idle cycle between periods.
// TESTING
//  1. Clean burst: low=3, high=2, glitch_en=0, n=2 -> d_out 000110001100
//     then 0. period_done at cycles 5 and 10 after LOW entry. busy falls
//     after the 10th cycle.
//  2. Glitch: low=3, high=5, gap=1, glitch_w=1, glitch_en=1, n=1 ->
//     d_out 000 11111 0 1 0. period_done coincides with the glitch cycle.
//  3. Zero lengths: low=0, high=0, glitch_w=0, GLITCH_W=1 -> every phase
//     lasts 1 cycle. Pattern 01, or 0101 with gap=0 and glitch_en=1.
//  4. Continuous + stop: n=0, low=2, high=2. Assert stop in mid-HIGH of
//     period 4 -> that high completes (2 cycles). Then IDLE, d_out=0,
//     exactly 4 period_done pulses.
//  5. Reset mid-pulse: rst_n low during HIGH -> d_out=0 and busy=0 with no
//     clock edge. No period_done. After release, restart with the same
//     settings reproduces test 1 exactly.
//  6. Ignored inputs: start and changed high_len mid-burst -> waveform
//     unchanged. Simultaneous start+stop in IDLE -> exactly one period.

Source files
------------

// File: rtl/dwave_gen.sv
// Programmable pulse-train generator: LOW/HIGH periods with an optional trailing
// glitch pulse, bursts of n_periods or continuous until stop.
module dwave_gen #(
   parameter int CNT_W    = 8,
   parameter int GLITCH_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] low_len,
   input  logic [CNT_W-1:0] high_len,
   input  logic             glitch_en,
   input  logic [CNT_W-1:0] glitch_gap,
   input  logic [CNT_W-1:0] glitch_w,
   input  logic [CNT_W-1:0] n_periods,
   output logic             d_out,
   output logic             busy,
   output logic             period_done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOW  = 3'd1;
   localparam logic [2:0] S_HIGH = 3'd2;
   localparam logic [2:0] S_GAP  = 3'd3;
   localparam logic [2:0] S_GLIT = 3'd4;

   localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] GW_RAW  = CNT_W'(GLITCH_W);
   localparam logic [CNT_W-1:0] GW_DFLT = (GW_RAW == ZERO) ? ONE : GW_RAW;

   // A programmed length of zero still occupies one cycle.
   function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len,
                                                input logic [CNT_W-1:0] dflt);
      return (len == ZERO) ? dflt : len;
   endfunction

   logic [2:0]       state_r, nxt_state_s;
   logic [CNT_W-1:0] cnt_r, nxt_cnt_s;
   logic [CNT_W-1:0] pcnt_r, nxt_pcnt_s;
   logic             stop_pend_r, nxt_stop_s;
   logic [CNT_W-1:0] low_r, high_r, gap_r, gw_r, n_r;
   logic             gen_r;
   logic [CNT_W-1:0] cur_len_s;
   logic             last_s, eop_s, pd_nxt_s;
   logic             d_out_r, busy_r, pd_r;

   assign d_out       = d_out_r;
   assign busy        = busy_r;
   assign period_done = pd_r;

   // Length of the phase currently being timed.
   always_comb begin
      cur_len_s = ONE;
      case (state_r)
         S_LOW:   cur_len_s = low_r;
         S_HIGH:  cur_len_s = high_r;
         S_GAP:   cur_len_s = gap_r;
         S_GLIT:  cur_len_s = gw_r;
         default: cur_len_s = ONE;
      endcase
   end

   assign last_s = (cnt_r == (cur_len_s - ONE));

   // Next-state, phase counter, period counter and pending-stop logic.
   always_comb begin
      nxt_state_s = state_r;
      nxt_cnt_s   = cnt_r + ONE;
      nxt_pcnt_s  = pcnt_r;
      nxt_stop_s  = stop_pend_r | stop;
      eop_s       = 1'b0;
      case (state_r)
         S_IDLE: begin
            nxt_cnt_s = ZERO;
            if (start) begin
               nxt_state_s = S_LOW;
               nxt_pcnt_s  = ZERO;
               nxt_stop_s  = stop;
            end else begin
               nxt_stop_s  = 1'b0;
            end
         end
         S_LOW: begin
            if (last_s) begin
               nxt_state_s = S_HIGH;
               nxt_cnt_s   = ZERO;
            end else begin
               nxt_state_s = S_LOW;
            end
         end
         S_HIGH: begin
            if (last_s && gen_r) begin
               nxt_state_s = S_GAP;
               nxt_cnt_s   = ZERO;
            end else begin
               eop_s = last_s;
            end
         end
         S_GAP: begin
            if (last_s) begin
               nxt_state_s = S_GLIT;
               nxt_cnt_s   = ZERO;
            end else begin
               nxt_state_s = S_GAP;
            end
         end
         S_GLIT: begin
            eop_s = last_s;
         end
         default: begin
            nxt_state_s = S_IDLE;
            nxt_cnt_s   = ZERO;
            nxt_stop_s  = 1'b0;
         end
      endcase
      // A stop arriving on the final cycle still ends the burst at this boundary.
      if (eop_s) begin
         nxt_pcnt_s = pcnt_r + ONE;
         nxt_cnt_s  = ZERO;
         if (stop_pend_r || stop || ((n_r != ZERO) && ((pcnt_r + ONE) == n_r))) begin
            nxt_state_s = S_IDLE;
            nxt_stop_s  = 1'b0;
         end else begin
            nxt_state_s = S_LOW;
         end
      end else begin
         nxt_pcnt_s = nxt_pcnt_s;
      end
   end

   // period_done is registered, so it is predicted from the upcoming state/count.
   always_comb begin
      pd_nxt_s = ((nxt_state_s == S_HIGH) && !gen_r && (nxt_cnt_s == (high_r - ONE))) ||
                 ((nxt_state_s == S_GLIT) && (nxt_cnt_s == (gw_r - ONE)));
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         cnt_r       <= ZERO;
         pcnt_r      <= ZERO;
         stop_pend_r <= 1'b0;
         d_out_r     <= 1'b0;
         busy_r      <= 1'b0;
         pd_r        <= 1'b0;
      end else begin
         state_r     <= nxt_state_s;
         cnt_r       <= nxt_cnt_s;
         pcnt_r      <= nxt_pcnt_s;
         stop_pend_r <= nxt_stop_s;
         d_out_r     <= (nxt_state_s == S_HIGH) || (nxt_state_s == S_GLIT);
         busy_r      <= (nxt_state_s != S_IDLE);
         pd_r        <= pd_nxt_s;
      end
   end

   // Burst settings captured on an accepted start and frozen for the burst.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         low_r  <= ZERO;
         high_r <= ZERO;
         gap_r  <= ZERO;
         gw_r   <= ZERO;
         n_r    <= ZERO;
         gen_r  <= 1'b0;
      end else if ((state_r == S_IDLE) && start) begin
         low_r  <= eff_len(low_len, ONE);
         high_r <= eff_len(high_len, ONE);
         gap_r  <= eff_len(glitch_gap, ONE);
         gw_r   <= eff_len(glitch_w, GW_DFLT);
         n_r    <= n_periods;
         gen_r  <= glitch_en;
      end else begin
         gen_r  <= gen_r;
      end
   end

endmodule
